qbus_reset_seq: RTL and testbench

Parametrised power/reset sequencer for Q-bus CPU systems. It turns N raw, bouncy, active-low reset/power-fail sources into a properly ordered DCLO/ACLO pair for the CPU core, plus a `ready` flag. It supersedes the ad-hoc 8-bit reset stretcher in board top levels and sits between board buttons/supervisors and the CPU `pin_dclo_n`/`pin_aclo_n` inputs. The top level inverts the active-high outputs and drives the pins open-drain.

---
 rtl/rstseq_pkg.sv | 13 +
 rtl/rstseq_debounce.sv | 53 +++++
 rtl/qbus_reset_seq.sv | 90 +++++++++
 tb/tb_qbus_reset_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rstseq_pkg.sv
// rstseq_pkg: sequencer state encoding and shared counter sizing for qbus_reset_seq
package rstseq_pkg;

  typedef enum logic [2:0] {S_DCLO, S_ACLO, S_RUN, S_AONLY, S_PF} state_e;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rstseq_debounce.sv
// rstseq_debounce: 2-flop synchroniser for one active-low source, debounced when QBUS_RSTSEQ_DEBOUNCE_EN is defined
module rstseq_debounce #(
  parameter int DEB_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic src_n,
  output logic act
);

  if (DEB_W < 1) begin : g_bad_w
    $error("rstseq_debounce: DEB_W must be >= 1");
  end

  logic s1_q, s2_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= src_n;
      s2_q <= s1_q;
    end

`ifdef QBUS_RSTSEQ_DEBOUNCE_EN
  logic             last_q, act_q, act_d, chg;
  logic [DEB_W-1:0] cnt_q, cnt_d;

  // act only follows the input once it has been quiet for a full window
  always_comb begin
    chg   = s2_q != last_q;
    cnt_d = chg ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    act_d = (&cnt_q && !chg) ? ~s2_q : act_q;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_q <= 1'b1;
      cnt_q  <= '0;
      act_q  <= 1'b0;
    end else begin
      last_q <= s2_q;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
    end

  assign act = act_q;
`else
  assign act = ~s2_q;
`endif

endmodule

// File: rtl/qbus_reset_seq.sv
// qbus_reset_seq: orders DCLO/ACLO for a Q-bus CPU from N debounced reset/power-fail sources
// Optional debounce per channel: define QBUS_RSTSEQ_DEBOUNCE_EN.
module qbus_reset_seq
  import rstseq_pkg::*;
#(
  parameter int               N_SRC    = 1,
  parameter logic [N_SRC-1:0] SRC_MODE = {N_SRC{1'b1}},
  parameter int               DEB_W    = 8,
  parameter int               DCLO_DLY = 256,
  parameter int               ACLO_DLY = 64,
  parameter int               PF_DLY   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_n,
  output logic             dclo,
  output logic             aclo,
  output logic             ready,
  output logic [N_SRC-1:0] src_act
);

  localparam int            CW      = cnt_width(DCLO_DLY, ACLO_DLY, PF_DLY);
  localparam logic [CW-1:0] DC_LAST = CW'(DCLO_DLY - 1);
  localparam logic [CW-1:0] AC_LAST = CW'(ACLO_DLY - 1);
  localparam logic [CW-1:0] PF_LAST = CW'(PF_DLY - 1);

  if (DCLO_DLY < 1 || ACLO_DLY < 1 || PF_DLY < 1 || DEB_W < 1) begin : g_bad_cfg
    $error("qbus_reset_seq: DCLO_DLY, ACLO_DLY, PF_DLY and DEB_W must be >= 1");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dclo_q, aclo_q, ready_q;
  logic          full_req, pf_req;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    rstseq_debounce #(.DEB_W(DEB_W)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .src_n(src_n[i]),
      .act  (src_act[i])
    );
  end

  assign full_req = |(src_act & SRC_MODE);
  assign pf_req   = |(src_act & ~SRC_MODE);

  // cnt is cleared on every state change, so it never exceeds the longest delay
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      S_DCLO: begin
        state_d = (!full_req && cnt_q == DC_LAST) ? S_ACLO : S_DCLO;
        cnt_d   = (full_req || cnt_q == DC_LAST) ? '0 : cnt_q + 1'b1;
      end
      S_ACLO: begin
        state_d = full_req ? S_PF : (cnt_q == AC_LAST) ? S_RUN : S_ACLO;
        cnt_d   = (full_req || cnt_q == AC_LAST) ? '0 : cnt_q + 1'b1;
      end
      S_RUN:   state_d = full_req ? S_PF : pf_req ? S_AONLY : S_RUN;
      S_AONLY: state_d = full_req ? S_PF : pf_req ? S_AONLY : S_ACLO;
      S_PF: begin
        state_d = (cnt_q == PF_LAST) ? S_DCLO : S_PF;
        cnt_d   = (cnt_q == PF_LAST) ? '0 : cnt_q + 1'b1;
      end
      default: state_d = S_DCLO;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_DCLO;
      cnt_q   <= '0;
      dclo_q  <= 1'b1;
      aclo_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dclo_q  <= state_d == S_DCLO;
      aclo_q  <= state_d != S_RUN;
      ready_q <= state_d == S_RUN;
    end

  assign dclo  = dclo_q;
  assign aclo  = aclo_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_qbus_reset_seq.sv
// tb_qbus_reset_seq: self-checking bench for qbus_reset_seq against a behavioural sequencer model
module tb_qbus_reset_seq;

  localparam int         N        = 2;
  localparam logic [1:0] MODE     = 2'b01;
  localparam int         DEB_W    = 3;
  localparam int         DCLO_DLY = 8;
  localparam int         ACLO_DLY = 4;
  localparam int         PF_DLY   = 6;
`ifdef QBUS_RSTSEQ_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int WIN     = (1 << DEB_W) + 1;
  localparam int HL      = WIN + 2;
  localparam int ACT_LAT = DEB_EN ? (1 << DEB_W) + 3 : 2;
  localparam int LIM     = 100;

  localparam int W_DCLO = 0, W_ACLO = 1, W_READY = 2, W_ACT0 = 3, W_ACT1 = 4;
  localparam int P_HOLD_DC = 0, P_HOLD_AC = 1, P_RUN = 2, P_AC_ONLY = 3, P_LEAD = 4;

  logic       clk = 1'b0, rst = 1'b0;
  logic [1:0] src_n = 2'b11;
  logic       dclo, aclo, ready;
  logic [1:0] src_act;
  int         n_chk = 0, n_fail = 0;
  bit         chk_en = 1'b0;

  qbus_reset_seq #(
    .N_SRC(N), .SRC_MODE(MODE), .DEB_W(DEB_W),
    .DCLO_DLY(DCLO_DLY), .ACLO_DLY(ACLO_DLY), .PF_DLY(PF_DLY)
  ) dut (
    .clk(clk), .rst(rst), .src_n(src_n),
    .dclo(dclo), .aclo(aclo), .ready(ready), .src_act(src_act)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endfunction

  // behavioural model: sources as raw sample history, sequencer as phases with countdown timers
  int         phase, left;
  logic [1:0] m_act;
  logic [1:0] hist[$];
  logic       m_full, m_pf, m_stable;

  task automatic model_reset();
    phase = P_HOLD_DC;
    left  = DCLO_DLY;
    m_act = '0;
    hist  = {};
    for (int j = 0; j < HL; j++) hist.push_back(2'b11);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      m_full = |(m_act & MODE);
      m_pf   = |(m_act & ~MODE);
      case (phase)
        P_HOLD_DC:
          if (m_full) left = DCLO_DLY;
          else if (left == 1) begin phase = P_HOLD_AC; left = ACLO_DLY; end
          else left--;
        P_HOLD_AC:
          if (m_full) begin phase = P_LEAD; left = PF_DLY; end
          else if (left == 1) phase = P_RUN;
          else left--;
        P_RUN:
          if (m_full) begin phase = P_LEAD; left = PF_DLY; end
          else if (m_pf) phase = P_AC_ONLY;
        P_AC_ONLY:
          if (m_full) begin phase = P_LEAD; left = PF_DLY; end
          else if (!m_pf) begin phase = P_HOLD_AC; left = ACLO_DLY; end
        default:
          if (left == 1) begin phase = P_HOLD_DC; left = DCLO_DLY; end
          else left--;
      endcase
      hist.push_back(src_n);
      void'(hist.pop_front());
      // hist[WIN-1] is the sample two edges ago; hist[0..WIN-1] is the stability window
      for (int c = 0; c < N; c++) begin
        if (DEB_EN) begin
          m_stable = 1'b1;
          for (int j = 0; j < WIN; j++) if (hist[j][c] != hist[WIN-1][c]) m_stable = 1'b0;
          if (m_stable) m_act[c] = ~hist[WIN-1][c];
        end else m_act[c] = ~hist[HL-2][c];
      end
    end
  end

  always @(negedge clk)
    if (chk_en) begin
      chk("model dclo", int'(dclo), int'(phase == P_HOLD_DC));
      chk("model aclo", int'(aclo), int'(phase != P_RUN));
      chk("model ready", int'(ready), int'(phase == P_RUN));
      chk("model src_act", int'(src_act), int'(m_act));
    end

  function automatic logic sig(input int w);
    case (w)
      W_DCLO:  return dclo;
      W_ACLO:  return aclo;
      W_READY: return ready;
      W_ACT0:  return src_act[0];
      default: return src_act[1];
    endcase
  endfunction

  // counts rising edges until the signal takes value v; returns LIM+1 on timeout
  task automatic wait_for(input int w, input logic v, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (sig(w) !== v && n <= LIM);
  endtask

  task automatic drive(input logic [1:0] v);
    @(posedge clk);
    #2 src_n = v;
  endtask

  task automatic power_up(input string tag);
    int n;
    @(posedge clk);
    #2 rst = 1'b0;
    wait_for(W_DCLO, 1'b0, n);
    chk({tag, " dclo release"}, n, DCLO_DLY);
    wait_for(W_ACLO, 1'b0, n);
    chk({tag, " aclo release"}, n, ACLO_DLY);
    chk({tag, " ready"}, int'(ready), 1);
  endtask

  typedef struct {
    logic [1:0] src;
    int         hold;
    logic       dclo, aclo, ready;
    logic [1:0] act;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int n;
    bit f1, f2;
    tbl[0] = '{2'b11, 40, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[1] = '{2'b10, 40, 1'b1, 1'b1, 1'b0, 2'b01};
    tbl[2] = '{2'b11, 40, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[3] = '{2'b01, 40, 1'b0, 1'b1, 1'b0, 2'b10};
    tbl[4] = '{2'b00, 40, 1'b1, 1'b1, 1'b0, 2'b11};
    tbl[5] = '{2'b01, 40, 1'b0, 1'b1, 1'b0, 2'b10};
    tbl[6] = '{2'b11, 40, 1'b0, 1'b0, 1'b1, 2'b00};

    #1 rst = 1'b1;
    #2 chk_en = 1'b1;
    chk("reset dclo", int'(dclo), 1);
    chk("reset aclo", int'(aclo), 1);
    chk("reset ready", int'(ready), 0);
    chk("reset src_act", int'(src_act), 0);
    power_up("powerup");

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].src);
      repeat (tbl[i].hold) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d dclo", i), int'(dclo), int'(tbl[i].dclo));
      chk($sformatf("vec%0d aclo", i), int'(aclo), int'(tbl[i].aclo));
      chk($sformatf("vec%0d ready", i), int'(ready), int'(tbl[i].ready));
      chk($sformatf("vec%0d src_act", i), int'(src_act), int'(tbl[i].act));
    end

    f1 = 1'b0;
    f2 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #2 src_n[0] = (i < 40) ? (((i / 3) % 2) != 0) : 1'b1;
      @(negedge clk);
      f1 |= src_act[0];
      f2 |= !ready;
    end
    chk("bounce src_act seen", int'(f1), int'(!DEB_EN));
    chk("bounce ready dropped", int'(f2), int'(!DEB_EN));
    chk("bounce ready end", int'(ready), 1);

    drive(2'b10);
    wait_for(W_ACT0, 1'b1, n);
    chk("full act latency", n, ACT_LAT);
    wait_for(W_ACLO, 1'b1, n);
    chk("full aclo after act", n, 1);
    chk("full ready drop", int'(ready), 0);
    wait_for(W_DCLO, 1'b1, n);
    chk("full dclo after aclo", n, PF_DLY);
    repeat (30) @(posedge clk);
    drive(2'b11);
    wait_for(W_ACT0, 1'b0, n);
    chk("full act release", n, ACT_LAT);
    wait_for(W_DCLO, 1'b0, n);
    chk("full dclo hold", n, DCLO_DLY);
    wait_for(W_ACLO, 1'b0, n);
    chk("full aclo hold", n, ACLO_DLY);
    chk("full ready", int'(ready), 1);

    drive(2'b01);
    wait_for(W_ACT1, 1'b1, n);
    chk("pf act latency", n, ACT_LAT);
    wait_for(W_ACLO, 1'b1, n);
    chk("pf aclo after act", n, 1);
    f1 = 1'b0;
    f2 = 1'b0;
    repeat (20) begin
      @(negedge clk);
      f1 |= dclo;
      f2 |= !aclo;
    end
    chk("pf dclo seen", int'(f1), 0);
    chk("pf aclo gap", int'(f2), 0);
    drive(2'b11);
    wait_for(W_ACT1, 1'b0, n);
    chk("pf act release", n, ACT_LAT);
    wait_for(W_ACLO, 1'b0, n);
    chk("pf aclo release", n, 1 + ACLO_DLY);

    drive(2'b01);
    wait_for(W_ACT1, 1'b1, n);
    wait_for(W_ACLO, 1'b1, n);
    chk("esc aclo", n, 1);
    repeat (5) @(posedge clk);
    #1 chk("esc aonly dclo", int'(dclo), 0);
    drive(2'b00);
    wait_for(W_ACT0, 1'b1, n);
    chk("esc act latency", n, ACT_LAT);
    wait_for(W_DCLO, 1'b1, n);
    chk("esc dclo after act", n, 1 + PF_DLY);
    drive(2'b11);
    wait_for(W_ACT0, 1'b0, n);
    wait_for(W_DCLO, 1'b0, n);
    chk("esc dclo hold", n, DCLO_DLY);
    wait_for(W_ACLO, 1'b0, n);
    chk("esc aclo hold", n, ACLO_DLY);

    drive(2'b10);
    wait_for(W_ACT0, 1'b1, n);
    wait_for(W_ACLO, 1'b1, n);
    #1 chk("midrst pf dclo", int'(dclo), 0);
    rst = 1'b1;
    #1;
    chk("midrst dclo", int'(dclo), 1);
    chk("midrst aclo", int'(aclo), 1);
    chk("midrst ready", int'(ready), 0);
    chk("midrst src_act", int'(src_act), 0);
    src_n = 2'b11;
    repeat (2) @(posedge clk);
    power_up("midrst powerup");

    for (int s = 0; s < 80; s++) begin
      @(posedge clk);
      #2 src_n = 2'($urandom_range(0, 3));
      repeat (($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40)) @(posedge clk);
    end
    drive(2'b11);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("random settle ready", int'(ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
